// File: rtl/hssl_rx_link_mon.sv
// rtl/hssl_rx_link_mon.sv - HSSL receive link monitor: word classification, lock FSM, 2-entry output buffer, stats (HSSL_RX_MON_STATS_EN)
module hssl_rx_link_mon #(
    parameter int SYNC_CNT     = 16,
    parameter int ERR_THRESH   = 4,
    parameter int ERR_WIN_LOG2 = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rx_data_in,
    input  logic [3:0]  rx_charisk_in,
    input  logic [3:0]  rx_disperr_in,
    input  logic [3:0]  rx_encerr_in,
    input  logic        rx_bufstatus_in,
    input  logic        clear_cnts_in,
    output logic [31:0] dat_out,
    output logic        vld_out,
    input  logic        rdy_in,
    output logic        locked_out,
    output logic [15:0] err_cnt_out,
    output logic [15:0] drop_cnt_out
);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    logic [31:0]             rx_data_q;
    logic [3:0]              rx_charisk_q;
    logic [3:0]              rx_disperr_q;
    logic [3:0]              rx_encerr_q;
    logic                    rx_bufstatus_q;

    state_t                  state;
    logic [7:0]              idle_cnt;
    logic [7:0]              win_err;
    logic [7:0]              win_err_nxt;
    logic [ERR_WIN_LOG2-1:0] win_pos;

    logic                    is_err;
    logic                    is_idle;
    logic                    is_data;
    logic                    push;
    logic                    pop;
    logic                    drop;

    logic [31:0]             buf1_data;
    logic                    buf1_vld;

    // Capture the transceiver outputs once before any decision is made on them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_q      <= '0;
            rx_charisk_q   <= '0;
            rx_disperr_q   <= '0;
            rx_encerr_q    <= '0;
            rx_bufstatus_q <= 1'b0;
        end else begin
            rx_data_q      <= rx_data_in;
            rx_charisk_q   <= rx_charisk_in;
            rx_disperr_q   <= rx_disperr_in;
            rx_encerr_q    <= rx_encerr_in;
            rx_bufstatus_q <= rx_bufstatus_in;
        end
    end

    // Classify the registered word; a K flag anywhere but a byte-0 comma is a framing error
    always_comb begin
        is_idle = 1'b0;
        is_data = 1'b0;
        is_err  = (|rx_disperr_q) || (|rx_encerr_q) || rx_bufstatus_q;
        if (!is_err) begin
            if (rx_charisk_q == 4'b0001 && rx_data_q[7:0] == 8'hBC)
                is_idle = 1'b1;
            else if (rx_charisk_q == 4'b0000)
                is_data = 1'b1;
            else
                is_err = 1'b1;
        end
    end

    // Windowed error count: an error landing on the wrap opens the new window at 1
    always_comb begin
        win_err_nxt = win_err + {7'd0, is_err};
        if (win_pos == {ERR_WIN_LOG2{1'b1}})
            win_err_nxt = {7'd0, is_err};
    end

    assign push = (state == LOCKED) && is_data;
    assign pop  = vld_out && rdy_in;
    assign drop = push && vld_out && buf1_vld && !pop;

    // Lock acquisition and tracking with registered locked_out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            locked_out <= 1'b0;
            idle_cnt   <= '0;
            win_err    <= '0;
            win_pos    <= '0;
        end else begin
            case (state)
                HUNT: begin
                    if (is_idle) begin
                        state    <= CHECK;
                        idle_cnt <= 8'd1;
                    end
                end
                CHECK: begin
                    if (!is_idle) begin
                        state    <= HUNT;
                        idle_cnt <= '0;
                    end else if (idle_cnt + 8'd1 == 8'(SYNC_CNT)) begin
                        state      <= LOCKED;
                        locked_out <= 1'b1;
                        idle_cnt   <= '0;
                        win_err    <= '0;
                        win_pos    <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end
                LOCKED: begin
                    win_pos <= win_pos + 1'b1;
                    win_err <= win_err_nxt;
                    if (win_err_nxt >= 8'(ERR_THRESH)) begin
                        state      <= HUNT;
                        locked_out <= 1'b0;
                    end
                end
                default: begin
                    state      <= HUNT;
                    locked_out <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry buffer; the head entry drives dat_out/vld_out directly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dat_out   <= '0;
            vld_out   <= 1'b0;
            buf1_data <= '0;
            buf1_vld  <= 1'b0;
        end else if (pop) begin
            if (buf1_vld) begin
                dat_out  <= buf1_data;
                vld_out  <= 1'b1;
                buf1_vld <= push;
                if (push)
                    buf1_data <= rx_data_q;
            end else begin
                vld_out <= push;
                if (push)
                    dat_out <= rx_data_q;
            end
        end else if (push) begin
            if (!vld_out) begin
                vld_out <= 1'b1;
                dat_out <= rx_data_q;
            end else if (!buf1_vld) begin
                buf1_vld  <= 1'b1;
                buf1_data <= rx_data_q;
            end
        end
    end

`ifdef HSSL_RX_MON_STATS_EN
    logic [15:0] err_cnt;
    logic [15:0] drop_cnt;

    // Saturating statistics; clear wins over a coincident increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else if (clear_cnts_in) begin
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (is_err && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign err_cnt_out  = err_cnt;
    assign drop_cnt_out = drop_cnt;
`else
    logic unused_stats;
    assign unused_stats = ^{clear_cnts_in, drop};
    assign err_cnt_out  = '0;
    assign drop_cnt_out = '0;
`endif

endmodule

// File: tb/tb_hssl_rx_link_mon.sv
// tb/tb_hssl_rx_link_mon.sv - directed table-driven bench for hssl_rx_link_mon
module tb_hssl_rx_link_mon;

`ifdef HSSL_RX_MON_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [1:0] K_IDLE = 2'd0;
    localparam logic [1:0] K_DATA = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rx_data_in;
    logic [3:0]  rx_charisk_in;
    logic [3:0]  rx_disperr_in;
    logic [3:0]  rx_encerr_in;
    logic        rx_bufstatus_in;
    logic        clear_cnts_in;
    logic [31:0] dat_out;
    logic        vld_out;
    logic        rdy_in;
    logic        locked_out;
    logic [15:0] err_cnt_out;
    logic [15:0] drop_cnt_out;

    int checks = 0;
    int errors = 0;

    hssl_rx_link_mon dut (
        .clk             (clk),
        .reset           (reset),
        .rx_data_in      (rx_data_in),
        .rx_charisk_in   (rx_charisk_in),
        .rx_disperr_in   (rx_disperr_in),
        .rx_encerr_in    (rx_encerr_in),
        .rx_bufstatus_in (rx_bufstatus_in),
        .clear_cnts_in   (clear_cnts_in),
        .dat_out         (dat_out),
        .vld_out         (vld_out),
        .rdy_in          (rdy_in),
        .locked_out      (locked_out),
        .err_cnt_out     (err_cnt_out),
        .drop_cnt_out    (drop_cnt_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] data;
        int          n;
        logic        e_lock;
        logic        e_vld;
        logic [31:0] e_dat;
        logic [15:0] e_err;
        logic [15:0] e_drop;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [15:0] cnt_exp(input logic [15:0] v);
        return STATS ? v : 16'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic lock, input logic vld,
                            input logic [31:0] dat, input logic [15:0] err, input logic [15:0] drp);
        chk({name, ".locked"}, {31'd0, locked_out}, {31'd0, lock});
        chk({name, ".vld"}, {31'd0, vld_out}, {31'd0, vld});
        if (vld)
            chk({name, ".dat"}, dat_out, dat);
        chk({name, ".err_cnt"}, {16'd0, err_cnt_out}, {16'd0, cnt_exp(err)});
        chk({name, ".drop_cnt"}, {16'd0, drop_cnt_out}, {16'd0, cnt_exp(drp)});
    endtask

    task automatic drive(input logic [1:0] kind, input logic [31:0] d);
        rx_disperr_in   = 4'b0000;
        rx_encerr_in    = 4'b0000;
        rx_bufstatus_in = 1'b0;
        case (kind)
            K_IDLE: begin rx_data_in = 32'h000000BC; rx_charisk_in = 4'b0001; end
            K_DATA: begin rx_data_in = d; rx_charisk_in = 4'b0000; end
            default: begin rx_data_in = d; rx_charisk_in = 4'b0000; rx_encerr_in = 4'b0001; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [1:0] kind, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            drive(kind, d);
            tick();
        end
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        #2;
        chk_outs(name, 1'b0, 1'b0, 32'd0, 16'd0, 16'd0);
        chk({name, ".dat0"}, dat_out, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic lock_link(input string name);
        run(K_IDLE, 32'd0, 17);
        chk({name, ".lock"}, {31'd0, locked_out}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        rdy_in = 1'b1;
        clear_cnts_in = 1'b0;
        drive(K_DATA, 32'd0);

        // expected values are outputs after the last word of each row is registered
        tbl[0]  = '{K_IDLE, 32'h0,        16, 1'b0, 1'b0, 32'h0,        16'd0, 16'd0};
        tbl[1]  = '{K_DATA, 32'h12345678, 1,  1'b1, 1'b0, 32'h0,        16'd0, 16'd0};
        tbl[2]  = '{K_IDLE, 32'h0,        1,  1'b1, 1'b1, 32'h12345678, 16'd0, 16'd0};
        tbl[3]  = '{K_IDLE, 32'h0,        1,  1'b1, 1'b0, 32'h0,        16'd0, 16'd0};
        tbl[4]  = '{K_ERR,  32'h0,        3,  1'b1, 1'b0, 32'h0,        16'd2, 16'd0};
        tbl[5]  = '{K_ERR,  32'h0,        1,  1'b1, 1'b0, 32'h0,        16'd3, 16'd0};
        tbl[6]  = '{K_IDLE, 32'h0,        1,  1'b0, 1'b0, 32'h0,        16'd4, 16'd0};
        tbl[7]  = '{K_IDLE, 32'h0,        14, 1'b0, 1'b0, 32'h0,        16'd4, 16'd0};
        tbl[8]  = '{K_DATA, 32'hAAAA5555, 1,  1'b0, 1'b0, 32'h0,        16'd4, 16'd0};
        tbl[9]  = '{K_IDLE, 32'h0,        16, 1'b0, 1'b0, 32'h0,        16'd4, 16'd0};
        tbl[10] = '{K_DATA, 32'hCAFEF00D, 1,  1'b1, 1'b0, 32'h0,        16'd4, 16'd0};
        tbl[11] = '{K_IDLE, 32'h0,        1,  1'b1, 1'b1, 32'hCAFEF00D, 16'd4, 16'd0};
        tbl[12] = '{K_IDLE, 32'h0,        1,  1'b1, 1'b0, 32'h0,        16'd4, 16'd0};

        #1;
        do_reset("reset0");

        for (int r = 0; r < 13; r++) begin
            run(tbl[r].kind, tbl[r].data, tbl[r].n);
            chk_outs($sformatf("tbl%0d", r), tbl[r].e_lock, tbl[r].e_vld,
                     tbl[r].e_dat, tbl[r].e_err, tbl[r].e_drop);
        end

        // 3 errors, window wrap, 3 more errors: lock held
        do_reset("reset_w1");
        lock_link("w1");
        run(K_ERR, 32'h1, 3);
        run(K_IDLE, 32'h0, 260);
        run(K_ERR, 32'h2, 3);
        run(K_IDLE, 32'h0, 2);
        chk_outs("win_split", 1'b1, 1'b0, 32'h0, 16'd6, 16'd0);

        // error on the wrap word opens the new window at 1
        do_reset("reset_w2");
        lock_link("w2");
        run(K_IDLE, 32'h0, 251);
        run(K_ERR, 32'h3, 4);
        run(K_IDLE, 32'h0, 1);
        chk("wrap_err_hold", {31'd0, locked_out}, 32'd1);
        run(K_ERR, 32'h4, 2);
        run(K_ERR, 32'h4, 1);
        chk("wrap_carry_3", {31'd0, locked_out}, 32'd1);
        run(K_IDLE, 32'h0, 1);
        chk_outs("wrap_carry_4", 1'b0, 1'b0, 32'h0, 16'd7, 16'd0);

        // backpressure: 5 data words into a 2-entry buffer
        do_reset("reset_bp");
        lock_link("bp");
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(K_DATA, 32'hD000_0000 + i);
            tick();
        end
        run(K_IDLE, 32'h0, 1);
        chk_outs("bp_full", 1'b1, 1'b1, 32'hD000_0000, 16'd0, 16'd3);
        rdy_in = 1'b1;
        tick();
        chk_outs("bp_pop0", 1'b1, 1'b1, 32'hD000_0001, 16'd0, 16'd3);
        tick();
        chk_outs("bp_pop1", 1'b1, 1'b0, 32'h0, 16'd0, 16'd3);
        tick();
        chk_outs("bp_empty", 1'b1, 1'b0, 32'h0, 16'd0, 16'd3);

        // async reset with buffered words, then fresh relock
        do_reset("reset_r");
        lock_link("r");
        rdy_in = 1'b0;
        run(K_DATA, 32'hBEEF0001, 2);
        run(K_IDLE, 32'h0, 1);
        chk_outs("r_buffered", 1'b1, 1'b1, 32'hBEEF0001, 16'd0, 16'd0);
        do_reset("r_midreset");
        run(K_IDLE, 32'h0, 16);
        chk_outs("r_16idle", 1'b0, 1'b0, 32'h0, 16'd0, 16'd0);
        run(K_IDLE, 32'h0, 1);
        chk_outs("r_relock", 1'b1, 1'b0, 32'h0, 16'd0, 16'd0);
        rdy_in = 1'b1;

        // clear coinciding with an error word
        do_reset("reset_c");
        run(K_ERR, 32'h5, 3);
        chk_outs("c_pre", 1'b0, 1'b0, 32'h0, 16'd2, 16'd0);
        clear_cnts_in = 1'b1;
        run(K_IDLE, 32'h0, 1);
        clear_cnts_in = 1'b0;
        chk_outs("c_clear", 1'b0, 1'b0, 32'h0, 16'd0, 16'd0);
        run(K_ERR, 32'h6, 1);
        run(K_IDLE, 32'h0, 1);
        chk_outs("c_after", 1'b0, 1'b0, 32'h0, 16'd1, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
